dsp_pipe_ctrl: RTL and testbench

Control-side companion to the DSP48A1 datapath registers. It drives every stage register's CE and reset pins and tracks a valid token through each enabled register stage. It also wraps the multiply/accumulate slice in a valid/ready stream handshake with backpressure, drain and clear. It sits between the upstream operand source and the downstream P consumer; the datapath itself carries no handshake.

---
 rtl/dsp_pkg.sv | 7 +
 rtl/dsp_tok_shift.sv | 15 +
 rtl/dsp_pipe_ctrl.sv | 73 +++++++
 tb/tb_dsp_pipe_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: controller state encoding and pipeline depth helper
package dsp_pkg;
  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_e;
  function automatic int calc_l(input bit b0, input bit b1, input bit m, input bit p);
    return int'(b0) + int'(b1) + int'(m) + int'(p);
  endfunction
endpackage

// File: rtl/dsp_tok_shift.sv
// dsp_tok_shift: valid-token shift register with advance enable and synchronous clear
module dsp_tok_shift #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  input  logic         din_i,
  output logic [N-1:0] tok_o
);
  logic [N-1:0] tok_q, tok_d;
  always_comb tok_d = rst ? '0 : adv_i ? N'({tok_q, din_i}) : tok_q;
  always_ff @(posedge clk) tok_q <= tok_d;
  assign tok_o = tok_q;
endmodule

// File: rtl/dsp_pipe_ctrl.sv
// dsp_pipe_ctrl: CE/reset sequencing and valid/ready wrapper for the DSP48A1 stage registers
module dsp_pipe_ctrl
  import dsp_pkg::*;
#(
  parameter bit B0REG = 1'b1,
  parameter bit B1REG = 1'b1,
  parameter bit MREG  = 1'b1,
  parameter bit PREG  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       drain,
  input  logic       clr,
  output logic       CE_S1,
  output logic       CE_S2,
  output logic       CE_M,
  output logic       CE_P,
  output logic       stage_rst,
  output logic [2:0] inflight,
  output logic       busy
);
  localparam int L = calc_l(B0REG, B1REG, MREG, PREG);
  state_e state_q, state_d;
  logic [2:0] inflight_q, inflight_d;
  logic adv, ce, run, acc;
  assign adv = !(out_valid && !out_ready);
  assign ce = adv && !RST && !clr;
  assign run = state_q == RUN && !RST && !clr;
  assign acc = in_valid && in_ready;
  assign CE_S1 = B0REG && ce;
  assign CE_S2 = B1REG && ce;
  assign CE_M = MREG && ce;
  assign CE_P = PREG && ce;
  assign stage_rst = RST || clr || state_q == INIT;
  generate
    if (L == 0) begin : g_comb
      assign in_ready = out_ready && run;
      assign out_valid = in_valid && run;
    end else begin : g_pipe
      logic [L-1:0] tok;
      dsp_tok_shift #(.N(L)) u_tok (
        .clk  (CLK),
        .rst  (RST || clr),
        .adv_i(adv),
        .din_i(acc),
        .tok_o(tok)
      );
      assign out_valid = tok[L-1] && !RST;
      assign in_ready = adv && run;
    end
  endgenerate
  always_comb begin
    inflight_d = (L == 0 || clr) ? '0 : inflight_q + {2'b0, acc} - {2'b0, out_valid && out_ready};
    state_d = (clr || state_q == INIT) ? RUN :
              state_q == RUN ? (drain ? DRAIN : RUN) :
              (inflight_q == '0 ? RUN : DRAIN);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= INIT;
      inflight_q <= '0;
    end else begin
      state_q <= state_d;
      inflight_q <= inflight_d;
    end
  end
  assign inflight = inflight_q;
  assign busy = state_q != RUN || inflight_q != '0;
endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// tb_dsp_pipe_ctrl: scoreboard bench for the pipeline controller across stage configurations
module tb_dsp_pipe_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rst_a, iv_a, or_a, dr_a, cl_a;
  logic ir_a, ov_a, s1_a, s2_a, m_a, p_a, srst_a, busy_a;
  logic [2:0] infl_a;
  logic [7:0] tag_a, r1, r2, rm, rp, e;
  dsp_pipe_ctrl u_a (
    .CLK(clk), .RST(rst_a), .in_valid(iv_a), .in_ready(ir_a), .out_valid(ov_a), .out_ready(or_a),
    .drain(dr_a), .clr(cl_a), .CE_S1(s1_a), .CE_S2(s2_a), .CE_M(m_a), .CE_P(p_a),
    .stage_rst(srst_a), .inflight(infl_a), .busy(busy_a)
  );
  always @(posedge clk) begin
    if (srst_a) {r1, r2, rm, rp} <= '0;
    else begin
      if (s1_a) r1 <= tag_a;
      if (s2_a) r2 <= r1;
      if (m_a) rm <= r2;
      if (p_a) rp <= rm;
    end
  end
  logic rst2, iv2, or2;
  logic dr2 = 1'b0, cl2 = 1'b0;
  logic ir_b, ov_b, c1_b, c2_b, cm_b, cp_b, sr_b, busy_b;
  logic ir_c, ov_c, c1_c, c2_c, cm_c, cp_c, sr_c, busy_c;
  logic ir_d, ov_d, c1_d, c2_d, cm_d, cp_d, sr_d, busy_d;
  logic [2:0] infl_b, infl_c, infl_d;
  dsp_pipe_ctrl #(.B0REG(1'b0), .B1REG(1'b0), .MREG(1'b1), .PREG(1'b0)) u_b (
    .CLK(clk), .RST(rst2), .in_valid(iv2), .in_ready(ir_b), .out_valid(ov_b), .out_ready(or2),
    .drain(dr2), .clr(cl2), .CE_S1(c1_b), .CE_S2(c2_b), .CE_M(cm_b), .CE_P(cp_b),
    .stage_rst(sr_b), .inflight(infl_b), .busy(busy_b)
  );
  dsp_pipe_ctrl #(.B0REG(1'b1), .B1REG(1'b0), .MREG(1'b0), .PREG(1'b1)) u_c (
    .CLK(clk), .RST(rst2), .in_valid(iv2), .in_ready(ir_c), .out_valid(ov_c), .out_ready(or2),
    .drain(dr2), .clr(cl2), .CE_S1(c1_c), .CE_S2(c2_c), .CE_M(cm_c), .CE_P(cp_c),
    .stage_rst(sr_c), .inflight(infl_c), .busy(busy_c)
  );
  dsp_pipe_ctrl #(.B0REG(1'b0), .B1REG(1'b0), .MREG(1'b0), .PREG(1'b0)) u_d (
    .CLK(clk), .RST(rst2), .in_valid(iv2), .in_ready(ir_d), .out_valid(ov_d), .out_ready(or2),
    .drain(dr2), .clr(cl2), .CE_S1(c1_d), .CE_S2(c2_d), .CE_M(cm_d), .CE_P(cp_d),
    .stage_rst(sr_d), .inflight(infl_d), .busy(busy_d)
  );
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  logic [7:0] q[$];
  int got = 0, first_acc = -1, first_ov = -1, run_len = 0, max_run = 0, max_infl = 0;
  always @(negedge clk) begin : push
    if (rst_a || cl_a) q.delete();
    else if (iv_a && ir_a) begin
      q.push_back(tag_a);
      if (first_acc < 0) first_acc = cyc;
    end
  end
  always @(negedge clk) begin : mon
    run_len = ov_a ? run_len + 1 : 0;
    if (run_len > max_run) max_run = run_len;
    if (int'(infl_a) > max_infl) max_infl = int'(infl_a);
    if (ov_a && first_ov < 0) first_ov = cyc;
    if (ov_a && or_a) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_empty: got tag %0d expected no result", rp);
      end else begin
        e = q.pop_front();
        got++;
        if (rp !== e) begin
          failures++;
          $display("FAIL sb_tag: got %0d expected %0d", rp, e);
        end
      end
    end
  end
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    int sent, nl, nb, nc;
    rst_a = 1; iv_a = 0; or_a = 1; dr_a = 0; cl_a = 0; tag_a = 0;
    rst2 = 1; iv2 = 0; or2 = 1;
    step; step; #2;
    chk("rst_ready", ir_a, 0); chk("rst_ov", ov_a, 0); chk("rst_infl", infl_a, 0);
    chk("rst_ce", {s1_a, s2_a, m_a, p_a}, 0); chk("rst_srst", srst_a, 1); chk("rst_busy", busy_a, 1);
    step; rst_a = 0; #2;
    chk("init_ready", ir_a, 0); chk("init_srst", srst_a, 1); chk("init_busy", busy_a, 1);
    for (int i = 0; i < 8; i++) begin
      step; iv_a = 1; tag_a = 8'(i); #2;
      chk("s1_ready", ir_a, 1);
    end
    step; iv_a = 0;
    for (int k = 0; k < 12 && infl_a != 0; k++) step;
    #2;
    chk("s1_empty", infl_a, 0); chk("s1_latency", first_ov - first_acc, 4);
    chk("s1_count", got, 8); chk("s1_run", max_run, 8); chk("s1_peak", max_infl, 4);
    sent = 0;
    for (int j = 0; j < 40 && sent < 8; j++) begin
      step; or_a = !(j >= 6 && j <= 10); iv_a = 1; tag_a = 8'(8 + sent); #2;
      if (j == 6) chk("bp_infl", infl_a, 4);
      if (j >= 6 && j <= 10) begin
        chk("bp_ce", {s1_a, s2_a, m_a, p_a}, 0); chk("bp_ready", ir_a, 0);
        chk("bp_ov", ov_a, 1); chk("bp_p", rp, 10);
      end
      if (iv_a && ir_a) sent++;
    end
    step; iv_a = 0; or_a = 1;
    for (int k = 0; k < 12 && infl_a != 0; k++) step;
    #2;
    chk("bp_count", got, 16); chk("bp_queue", q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      step; iv_a = 1; tag_a = 8'(32 + i);
    end
    step; iv_a = 0; dr_a = 1; #2;
    chk("dr_start_infl", infl_a, 3);
    for (int i = 0; i < 4; i++) begin
      step; dr_a = 0; iv_a = 1; tag_a = 99; #2;
      chk("dr_ready", ir_a, 0); chk("dr_infl", infl_a, 3 - i); chk("dr_busy", busy_a, 1);
    end
    step; iv_a = 0; #2;
    chk("dr_run_ready", ir_a, 1); chk("dr_busy_fall", busy_a, 0); chk("dr_count", got, 19);
    for (int i = 0; i < 4; i++) begin
      step; iv_a = 1; or_a = 0; tag_a = 8'(40 + i); #2;
      chk("cl_fill_ready", ir_a, 1);
    end
    step; iv_a = 0; #2;
    chk("cl_full_infl", infl_a, 4); chk("cl_full_ov", ov_a, 1); chk("cl_full_ready", ir_a, 0);
    step; cl_a = 1; #2;
    chk("cl_srst", srst_a, 1); chk("cl_ce", {s1_a, s2_a, m_a, p_a}, 0); chk("cl_ready", ir_a, 0);
    step; cl_a = 0; or_a = 1; #2;
    chk("cl_infl", infl_a, 0); chk("cl_ov", ov_a, 0); chk("cl_busy", busy_a, 0);
    step; iv_a = 1; tag_a = 77; #2;
    chk("cl_acc_ready", ir_a, 1);
    nl = 0;
    for (int n = 1; n <= 8 && nl == 0; n++) begin
      step; iv_a = 0; #2;
      if (ov_a) nl = n;
    end
    chk("cl_latency", nl, 4);
    step; iv_a = 1; tag_a = 80;
    step; tag_a = 81;
    step; iv_a = 0; cl_a = 1; dr_a = 1; #2;
    chk("cd_srst", srst_a, 1);
    step; cl_a = 0; dr_a = 0; #2;
    chk("cd_ready", ir_a, 1); chk("cd_busy", busy_a, 0); chk("cd_infl", infl_a, 0);
    step; iv_a = 1; tag_a = 90;
    step; tag_a = 91;
    step; iv_a = 0; dr_a = 1;
    step; dr_a = 0; #2;
    chk("rd_drain_ready", ir_a, 0); chk("rd_drain_busy", busy_a, 1);
    step; rst_a = 1; #2;
    chk("rd_rst_ready", ir_a, 0); chk("rd_rst_ov", ov_a, 0); chk("rd_rst_srst", srst_a, 1);
    step; rst_a = 0; #2;
    chk("rd_init_srst", srst_a, 1); chk("rd_init_ready", ir_a, 0);
    chk("rd_init_busy", busy_a, 1); chk("rd_init_infl", infl_a, 0);
    step; #2;
    chk("rd_run_ready", ir_a, 1); chk("rd_run_busy", busy_a, 0);
    step; rst2 = 0;
    step; iv2 = 0; or2 = 1; #2;
    chk("l0_idle_ov", ov_d, 0); chk("l0_idle_ready", ir_d, 1); chk("l0_infl", infl_d, 0);
    iv2 = 1; or2 = 0; #2;
    chk("l0_ov", ov_d, 1); chk("l0_stall_ready", ir_d, 0);
    or2 = 1; #2;
    chk("l0_ready", ir_d, 1); chk("l1_ce_s1", c1_b, 0); chk("l1_ce_m", cm_b, 1);
    chk("l1_ready", ir_b, 1); chk("l2_ready", ir_c, 1);
    nb = 0; nc = 0;
    for (int n = 1; n <= 6; n++) begin
      step; iv2 = 0; #2;
      if (ov_b && nb == 0) nb = n;
      if (ov_c && nc == 0) nc = n;
    end
    chk("l1_latency", nb, 1); chk("l2_latency", nc, 2); chk("l0_after_ov", ov_d, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
